// File: rtl/fifo_rd_stream.sv
// Read-side adapter: prefetches FIFO entries into a small circular buffer
// and presents them as a valid/ready stream with one beat per cycle.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  areset_b,
  input  logic                  fifo_empty_ind,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  trans_read,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CW-1:0]         buf_count,
  output logic [CNT_WIDTH-1:0]  beat_count
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;

  logic                  pop;
  logic                  capture;
  logic [CW:0]           need;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_valid    = (count_q != '0);
  assign m_data     = buf_q[head_q];
  assign buf_count  = count_q;
  assign beat_count = beat_q;
  assign pop        = m_valid & m_ready;
  assign capture    = inflight_q & ~flush;

  // Occupancy after this edge if a read were issued now; pop frees a slot
  // in the same cycle so a ready consumer never sees a bubble.
  assign need = {1'b0, count_q}
              + {{CW{1'b0}}, inflight_q}
              - {{CW{1'b0}}, pop};

  assign trans_read = ~fifo_empty_ind & ~flush
                    & (need < (CW + 1)'(BUF_DEPTH));

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = trans_read;
    beat_d     = beat_q;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (capture) tail_d = nxt(tail_q);
      if (pop) begin
        head_d = nxt(head_q);
        beat_d = beat_q + 1'b1;
      end
      count_d = count_q
              + {{(CW-1){1'b0}}, capture}
              - {{(CW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
    end
  end

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
    end else if (capture) begin
      buf_q[tail_q] <= fifo_data;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomised checks of fifo_rd_stream against a
// behavioural FIFO with one-cycle registered read data.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        areset_b = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        trans_read;
  logic        flush = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [1:0]  buf_count;
  logic [15:0] beat_count;

  logic        push = 1'b0;
  logic [31:0] push_d = '0;
  logic [31:0] mem [2048];
  logic [10:0] wr, rd;
  int          uf_err = 0;
  int          n_pass = 0;
  int          n_tot = 0;

  always #5 clk = ~clk;

  fifo_rd_stream dut (
    .clk_in(clk),
    .areset_b(areset_b),
    .fifo_empty_ind(fifo_empty),
    .fifo_data(fifo_data),
    .trans_read(trans_read),
    .flush(flush),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .buf_count(buf_count),
    .beat_count(beat_count)
  );

  assign fifo_empty = (wr == rd);

  always @(posedge clk or negedge areset_b) begin
    if (!areset_b) begin
      wr <= '0;
      rd <= '0;
      fifo_data <= '0;
    end else begin
      if (push) begin
        mem[wr] <= push_d;
        wr <= wr + 1'b1;
      end
      if (trans_read) begin
        fifo_data <= mem[rd];
        rd <= rd + 1'b1;
      end
    end
  end

  always @(posedge clk)
    if (areset_b && trans_read && fifo_empty) uf_err <= uf_err + 1;

  typedef struct {
    logic        rdy;
    logic        fl;
    logic        tr;
    logic        vld;
    logic [31:0] dat;
    logic [1:0]  cnt;
    logic [15:0] bc;
  } vec_t;

  vec_t tbl [30];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset_b = 1'b0;
    push = 1'b0;
    flush = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("rst_trans_read", trans_read, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_buf_count", buf_count, 0);
    chk("rst_beat_count", beat_count, 0);
    @(negedge clk);
    areset_b = 1'b1;
  endtask

  // Flush is held while loading so the adapter stays idle.
  task automatic preload(input logic [31:0] base, input int n,
                         input logic [31:0] step);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      flush = 1'b1;
      push = 1'b1;
      m_ready = 1'b0;
      push_d = base + step * i;
    end
  endtask

  task automatic run_seg(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      push = 1'b0;
      flush = tbl[i].fl;
      m_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_trans_read", i), trans_read, tbl[i].tr);
      chk($sformatf("v%0d_m_valid", i), m_valid, tbl[i].vld);
      chk($sformatf("v%0d_buf_count", i), buf_count, tbl[i].cnt);
      chk($sformatf("v%0d_beat_count", i), beat_count, tbl[i].bc);
      if (tbl[i].vld)
        chk($sformatf("v%0d_m_data", i), m_data, tbl[i].dat);
    end
  endtask

  initial begin
    int exp_n, sent, nerr, maxc, got;
    logic [31:0] bad_got, bad_exp;

    // rdy fl tr vld dat cnt bc : preload 11..44, consumer always ready
    tbl[0]  = '{1, 0, 1, 0, 32'h00, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 32'h00, 0, 0};
    tbl[2]  = '{1, 0, 1, 1, 32'h11, 1, 0};
    tbl[3]  = '{1, 0, 1, 1, 32'h22, 1, 1};
    tbl[4]  = '{1, 0, 0, 1, 32'h33, 1, 2};
    tbl[5]  = '{1, 0, 0, 1, 32'h44, 1, 3};
    tbl[6]  = '{1, 0, 0, 0, 32'h00, 0, 4};
    // back-pressure for 10 cycles, then release
    tbl[7]  = '{0, 0, 1, 0, 32'h00, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 32'h00, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 32'h11, 1, 0};
    for (int i = 10; i <= 16; i++)
      tbl[i] = '{0, 0, 0, 1, 32'h11, 2, 0};
    tbl[17] = '{1, 0, 1, 1, 32'h11, 2, 0};
    tbl[18] = '{1, 0, 1, 1, 32'h22, 1, 1};
    tbl[19] = '{1, 0, 0, 1, 32'h33, 1, 2};
    tbl[20] = '{1, 0, 0, 1, 32'h44, 1, 3};
    tbl[21] = '{1, 0, 0, 0, 32'h00, 0, 4};
    // flush with one buffered and one in flight, ready high in flush
    tbl[22] = '{0, 0, 1, 0, 32'h00, 0, 0};
    tbl[23] = '{0, 0, 1, 0, 32'h00, 0, 0};
    tbl[24] = '{1, 1, 0, 1, 32'h11, 1, 0};
    tbl[25] = '{1, 0, 1, 0, 32'h00, 0, 0};
    tbl[26] = '{1, 0, 1, 0, 32'h00, 0, 0};
    tbl[27] = '{1, 0, 0, 1, 32'h33, 1, 0};
    tbl[28] = '{1, 0, 0, 1, 32'h44, 1, 1};
    tbl[29] = '{1, 0, 0, 0, 32'h00, 0, 2};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("idle_trans_read", trans_read, 0);
    end

    do_reset();
    preload(32'h11, 4, 32'h11);
    run_seg(0, 6);

    do_reset();
    preload(32'h11, 4, 32'h11);
    run_seg(7, 21);

    do_reset();
    preload(32'h11, 4, 32'h11);
    run_seg(22, 29);

    // random back-pressure over an incrementing stream
    do_reset();
    exp_n = 0; sent = 0; nerr = 0; maxc = 0;
    bad_got = '0; bad_exp = '0;
    for (int cyc = 0; cyc < 6000 && exp_n < 1000; cyc++) begin
      @(negedge clk);
      flush = 1'b0;
      push = (sent < 1000);
      push_d = 32'h1000 + sent;
      if (push) sent++;
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (int'(buf_count) > maxc) maxc = int'(buf_count);
      if (m_valid && m_ready) begin
        if (m_data !== 32'h1000 + exp_n) begin
          if (nerr == 0) begin
            bad_got = m_data;
            bad_exp = 32'h1000 + exp_n;
          end
          nerr++;
        end
        exp_n++;
      end
    end
    @(negedge clk);
    push = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("rand_beats", exp_n, 1000);
    chk("rand_order_errs", nerr, 0);
    chk("rand_first_bad", bad_got, bad_exp);
    chk("rand_max_count", maxc, 2);
    chk("rand_beat_count", beat_count, 16'd1000);

    // asynchronous reset in the middle of a stream
    do_reset();
    preload(32'h50, 8, 32'h1);
    @(negedge clk);
    push = 1'b0;
    flush = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    areset_b = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_buf_count", buf_count, 0);
    chk("arst_beat_count", beat_count, 0);
    chk("arst_trans_read", trans_read, 0);
    chk("arst_m_data", m_data, 0);
    @(negedge clk);
    areset_b = 1'b1;
    preload(32'hA1, 2, 32'h1);
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
      @(negedge clk);
      push = 1'b0;
      flush = 1'b0;
      m_ready = 1'b1;
      #1;
      if (m_valid) begin
        chk("arst_restart_data", m_data, 32'hA1 + got);
        got++;
      end
    end
    chk("arst_restart_beats", got, 2);
    @(negedge clk);
    #1;
    chk("arst_restart_beat_count", beat_count, 2);
    chk("no_underflow", uf_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
